// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the existing receiver:
// transmitter state encoding, frame length, default timing constants.
package ps2_pkg;

  localparam int FRAME_BITS      = 10;
  localparam int INHIBIT_CYC_DEF = 6000;
  localparam int TIMEOUT_CYC_DEF = 1000000;
  localparam int FILT_LEN_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_FAIL      = 3'd6
  } ps2_tx_state_e;

  // Host frame after the start bit, LSB first: data[7:0], odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filt.sv
// One PS/2 line: 2-FF synchronizer, FILT_LEN-sample agreement filter and a
// one-cycle strobe on filtered 1->0. Idle level after reset is high.
module ps2_line_filt
  import ps2_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic          sync1_q, sync2_q, filt_q, fall_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      fall_q  <= 1'b0;
      // Any sample agreeing with the current filtered value restarts the run.
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= sync2_q;
        fall_q <= ~sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 10 device-clocked
// bits, ack). Define PS2_TX_RETRY_EN to retry once before reporting err.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] state_dbg
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

  ps2_tx_state_e         state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]         inh_cnt_q, inh_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  bit_oe_q, bit_oe_d;
`ifdef PS2_TX_RETRY_EN
  logic                  retry_q, retry_d;
`endif

  logic clk_filt, clk_fall, data_filt, data_fall_unused, timed_out;

  ps2_line_filt #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk(clk), .rst_n(rst_n), .line_i(ps2_clk_in), .filt_o(clk_filt), .fall_o(clk_fall)
  );

  ps2_line_filt #(.FILT_LEN(FILT_LEN)) u_data_filt (
    .clk(clk), .rst_n(rst_n), .line_i(ps2_data_in), .filt_o(data_filt), .fall_o(data_fall_unused)
  );

  // Handshake: tx_data is taken when tx_valid && tx_ready (IDLE only); there
  // is no queue, so tx_valid while busy is dropped.
  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = (state_q == ST_INHIBIT);
  assign ps2_data_oe = ((state_q == ST_INHIBIT) && (inh_cnt_q == INH_LAST)) ||
                       (state_q == ST_REQ) || ((state_q == ST_SHIFT) && bit_oe_q);
  assign state_dbg   = state_q;
  assign timed_out   = (to_cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_oe_d  = bit_oe_q;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          frame_d   = ps2_frame(tx_data);
          bit_cnt_d = '0;
          inh_cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 1'b0;
`endif
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          to_cnt_d = '0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ, ST_SHIFT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (timed_out) begin
          state_d = ST_FAIL;
        end else if (clk_fall) begin
          bit_oe_d  = ~frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == BIT_LAST) ? ST_ACK : ST_SHIFT;
        end
      end
      ST_ACK: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (timed_out)     state_d = ST_FAIL;
        else if (clk_fall) state_d = data_filt ? ST_FAIL : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (timed_out) begin
          state_d = ST_FAIL;
        end else if (clk_filt && data_filt) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: begin
`ifdef PS2_TX_RETRY_EN
        if (!retry_q) begin
          retry_d   = 1'b1;
          inh_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_INHIBIT;
        end else begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end
`else
        err     = 1'b1;
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_oe_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_oe_q  <= bit_oe_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

endmodule
